// File: rtl/vector_alu_pkg.sv
// Shared vector-ALU definitions: lane op encodings, divider width default and divider FSM states.
package vector_alu_pkg;

   localparam int VDIV_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7,
      ALU_MUL = 4'd8,
      ALU_DIV = 4'd9,
      ALU_REM = 4'd10
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } vdiv_state_t;

endpackage

// File: rtl/vdiv_step.sv
// One combinational restoring-division step: shift {rem,quo} left, then subtract the
// divisor from the partial remainder and keep the difference only if it is non-negative.
module vdiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;
   logic           take;

   // rem < divisor, so the shifted value needs one extra bit and the trial difference
   // always fits a WIDTH+1 two's-complement range: its top bit is the sign.
   assign rem_sh = {rem_i, quo_i[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, divisor_i};
   assign take   = ~trial[WIDTH];

   assign rem_o = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_o = {quo_i[WIDTH-2:0], take};

endmodule

// File: rtl/vector_div_seq.sv
// Multi-cycle restoring divider lane with valid/ready handshakes on both sides.
// Define VDIV_SIGNED_EN to honour op_signed (two's-complement, truncate toward zero).
module vector_div_seq
   import vector_alu_pkg::*;
#(
   parameter int WIDTH = VDIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   vdiv_state_t      state_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             dz_q;
   logic             out_valid_q, div_zero_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;

   logic [WIDTH-1:0] rem_d, quo_d;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH-1:0] q_fix, r_fix, dz_rem;

`ifdef VDIV_SIGNED_EN
   logic sa, sb;
   logic sa_q, neg_q;

   assign sa    = op_signed & dividend[WIDTH-1];
   assign sb    = op_signed & divisor[WIDTH-1];
   assign abs_a = sa ? -dividend : dividend;
   assign abs_b = sb ? -divisor  : divisor;

   // Re-applying the dividend sign to |dividend| recovers the raw dividend for divide-by-zero.
   assign q_fix  = neg_q ? -quo_q : quo_q;
   assign r_fix  = sa_q  ? -rem_q : rem_q;
   assign dz_rem = sa_q  ? -quo_q : quo_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q  <= 1'b0;
         neg_q <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         sa_q  <= sa;
         neg_q <= sa ^ sb;
      end
   end
`else
   logic unused_op_signed;

   assign unused_op_signed = op_signed;
   assign abs_a  = dividend;
   assign abs_b  = divisor;
   assign q_fix  = quo_q;
   assign r_fix  = rem_q;
   assign dz_rem = quo_q;
`endif

   vdiv_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (rem_d),
      .quo_o     (quo_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         dz_q        <= 1'b0;
         out_valid_q <= 1'b0;
         div_zero_q  <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  rem_q   <= '0;
                  quo_q   <= abs_a;
                  dvs_q   <= abs_b;
                  dz_q    <= (divisor == '0);
                  // A zero divisor skips the step loop: one frozen cycle, then FIX.
                  cnt_q   <= (divisor == '0) ? '0 : CW'(WIDTH - 1);
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (!dz_q) begin
                  rem_q <= rem_d;
                  quo_q <= quo_d;
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               quotient_q  <= dz_q ? '1 : q_fix;
               remainder_q <= dz_q ? dz_rem : r_fix;
               div_zero_q  <= dz_q;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_vector_div_seq.sv
// Randomised self-checking bench for vector_div_seq against an arithmetic reference model.
module tb_vector_div_seq;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             op_signed = 1'b0;
   logic [WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0] divisor = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_zero;
   logic             busy;

   vector_div_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_signed (op_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dz;
      int               lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic ov_prev = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference: plain integer division, truncating toward zero for signed operands.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic s);
      exp_t   e;
      logic   sg;
      longint sa, sb;
      logic [63:0] tq, tr;
`ifdef VDIV_SIGNED_EN
      sg = s;
`else
      sg = 1'b0 & s;
`endif
      if (b == '0) begin
         e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 2;
         return e;
      end
      e.dz = 1'b0;
      e.lat = WIDTH + 1;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         tq = 64'(sa / sb);
         tr = 64'(sa % sb);
      end else begin
         tq = {32'd0, a} / {32'd0, b};
         tr = {32'd0, a} % {32'd0, b};
      end
      e.q = tq[WIDTH-1:0];
      e.r = tr[WIDTH-1:0];
      return e;
   endfunction

   // Output checker: every cycle out_valid is high the results must match the pending op.
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy_vs_in_ready", {63'd0, busy}, {63'd0, ~in_ready});
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
            end else begin
               if (!ov_prev) chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
               chk("quotient", {32'd0, quotient}, {32'd0, exp_q[0].q});
               chk("remainder", {32'd0, remainder}, {32'd0, exp_q[0].r});
               chk("div_zero", {63'd0, div_zero}, {63'd0, exp_q[0].dz});
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         ov_prev = out_valid;
      end else begin
         ov_prev = 1'b0;
      end
   end

   task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
      exp_q.push_back(model(a, b, s));
      dividend = a; divisor = b; op_signed = s; in_valid = 1'b1;
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input int hold);
      int n = 0;
      out_ready = (hold == 0);
      start_op(a, b, s);
      $display("op a=%08h b=%08h signed=%0d hold=%0d", a, b, s, hold);
      while (!out_valid && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!out_valid) begin
         chk("result_timeout", {63'd0, out_valid}, 64'd1);
         exp_q.delete();
         return;
      end
      if (hold > 0) begin
         in_valid = 1'b1; dividend = $urandom; divisor = $urandom;
         for (int i = 0; i < hold; i++) begin
            chk("in_ready_while_done", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("in_ready_after_done", {63'd0, in_ready}, 64'd1);
      chk("out_valid_after_done", {63'd0, out_valid}, 64'd0);
   endtask

   exp_t pin;
   logic [WIDTH-1:0] ra, rb;

   initial begin
      // Pin the model to hand-computed values.
      pin = model(32'd100, 32'd7, 1'b0);
      chk("model_100_7_q", {32'd0, pin.q}, 64'd14);
      chk("model_100_7_r", {32'd0, pin.r}, 64'd2);
      pin = model(32'd5, 32'd0, 1'b0);
      chk("model_5_0_q", {32'd0, pin.q}, 64'hFFFF_FFFF);
      chk("model_5_0_r", {32'd0, pin.r}, 64'd5);
      pin = model(32'hFFFF_FFF9, 32'd2, 1'b1);
`ifdef VDIV_SIGNED_EN
      chk("model_m7_2_q", {32'd0, pin.q}, 64'hFFFF_FFFD);
      chk("model_m7_2_r", {32'd0, pin.r}, 64'hFFFF_FFFF);
      pin = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      chk("model_ovf_q", {32'd0, pin.q}, 64'h8000_0000);
      chk("model_ovf_r", {32'd0, pin.r}, 64'd0);
`else
      chk("model_m7_2_q", {32'd0, pin.q}, 64'h7FFF_FFFC);
      chk("model_m7_2_r", {32'd0, pin.r}, 64'd1);
`endif

      #1;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_quotient", {32'd0, quotient}, 64'd0);
      chk("rst_remainder", {32'd0, remainder}, 64'd0);
      chk("rst_div_zero", {63'd0, div_zero}, 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      run_op(32'd100, 32'd7, 1'b0, 0);
      run_op(32'd5, 32'd0, 1'b0, 0);
      run_op(32'd1000, 32'd13, 1'b0, 10);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 2);

      // Asynchronous reset during the 10th RUN step discards the in-flight result.
      out_ready = 1'b1;
      start_op(32'h1234_5678, 32'd3, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      exp_q.delete();
      chk("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("midrun_rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrun_rst_busy", {63'd0, busy}, 64'd0);
      chk("midrun_rst_quotient", {32'd0, quotient}, 64'd0);
      chk("midrun_rst_remainder", {32'd0, remainder}, 64'd0);
      chk("midrun_rst_div_zero", {63'd0, div_zero}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_op(32'd9, 32'd3, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = $urandom >> $urandom_range(0, 31);
            default: rb = $urandom;
         endcase
         run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
